// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the upstream 8-bit FIFO and sends each one
// as an asynchronous serial frame (start, DATA_W data bits LSB first, stop).
// Optional even-parity bit between data and stop: define FIFO_UART_TX_PARITY_EN.
//
// FIFO handshake: F_EMPTY_N acts as "valid" and READ as the pop strobe.
// READ is high for one cycle only, in POP, and only while F_EMPTY_N=1 and
// CLEAR_N=1. FIFO_DATA is taken on the following cycle (LOAD).
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_W   = 8
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CLEAR_N,
  input  logic              ENABLE,
  input  logic              F_EMPTY_N,
  input  logic [DATA_W-1:0] FIFO_DATA,
  output logic              READ,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        o_dbg_state
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
    , S_PARITY = 3'd6
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_baud;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              r_tx;
  logic              w_tx_nxt;
  logic              w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign TX          = r_tx;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; CLEAR_N forces IDLE over everything else.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ENABLE && F_EMPTY_N) w_state_nxt = S_POP;
      S_POP:   w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bit == BIT_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (w_bit_end) w_state_nxt = (ENABLE && F_EMPTY_N) ? S_POP : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!CLEAR_N) w_state_nxt = S_IDLE;
  end

  // FSM outputs: pop strobe, busy flag and end-of-stop pulse.
  always_comb begin
    READ = (r_state == S_POP) && F_EMPTY_N && CLEAR_N;
    BUSY = (r_state != S_IDLE);
    DONE = (r_state == S_STOP) && w_bit_end && CLEAR_N;
  end

  // Next shift value: load in LOAD, shift right at the end of each data bit.
  always_comb begin
    w_shift_nxt = r_shift;
    if (!CLEAR_N)                             w_shift_nxt = '0;
    else if (r_state == S_LOAD)               w_shift_nxt = FIFO_DATA;
    else if ((r_state == S_DATA) && w_bit_end) w_shift_nxt = r_shift >> 1;
  end

  // Line value for the coming cycle, derived from the next state so TX is
  // registered yet falls on the first START cycle.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_parity;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Datapath registers: line, shift register, baud and bit counters.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      if (!CLEAR_N) begin
        r_baud <= '0;
        r_bit  <= '0;
      end else begin
        // Counter runs only inside the serial frame; IDLE/POP/LOAD hold it at
        // zero so every frame starts its START bit from a clean count.
        if ((r_state == S_IDLE) || (r_state == S_POP) || (r_state == S_LOAD))
          r_baud <= '0;
        else
          r_baud <= w_bit_end ? '0 : r_baud + CW'(1);
        if (r_state == S_DATA) begin
          if (w_bit_end) r_bit <= (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
        end else begin
          r_bit <= '0;
        end
      end
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  // Even parity of the byte, captured alongside the shift register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)               r_parity <= 1'b0;
    else if (!CLEAR_N)          r_parity <= 1'b0;
    else if (r_state == S_LOAD) r_parity <= ^FIFO_DATA;
  end
`endif

endmodule
